// File: rtl/twiddle_cmult.sv
// Complex multiply of a sample by its twiddle factor, 3-cycle pipeline, round-half-up, with frame-last tracking.
// Define TWIDDLE_CMULT_SAT_EN to saturate out-of-range results; otherwise results wrap to NBITS.
module twiddle_cmult #(
   parameter int NBITS = 11,
   parameter int N     = 32,
   parameter int FRAC  = NBITS - 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*NBITS-1:0] data_in,
   input  logic               data_valid,
   input  logic [2*NBITS-1:0] coeff_in,
   output logic [2*NBITS-1:0] data_out,
   output logic               out_valid,
   output logic               out_last
);

   localparam int PW = 2 * NBITS;
   localparam int SW = 2 * NBITS + 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
   localparam logic signed [SW-1:0] HALF = SW'(1) <<< (FRAC - 1);

   logic [CW-1:0] cnt;

   logic signed [NBITS-1:0] ar, ai, br, bi;
   logic v1, l1;

   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic v2, l2;

   logic signed [SW-1:0] re_sum, im_sum, re_sh, im_sh;
   logic [NBITS-1:0] re_lim, im_lim;

   // Stage 1: frame position and valid/last tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         v1  <= 1'b0;
         l1  <= 1'b0;
      end else begin
         v1 <= data_valid;
         l1 <= data_valid && (cnt == LAST_CNT);
         if (data_valid) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (data_valid) begin
         ar <= $signed(data_in[PW-1:NBITS]);
         ai <= $signed(data_in[NBITS-1:0]);
         br <= $signed(coeff_in[PW-1:NBITS]);
         bi <= $signed(coeff_in[NBITS-1:0]);
      end
   end

   // Stage 2: the four full-width partial products
   always_ff @(posedge clk) begin
      if (rst) begin
         v2 <= 1'b0;
         l2 <= 1'b0;
      end else begin
         v2 <= v1;
         l2 <= l1;
      end
   end

   always_ff @(posedge clk) begin
      p_rr <= PW'(ar) * PW'(br);
      p_ii <= PW'(ai) * PW'(bi);
      p_ri <= PW'(ar) * PW'(bi);
      p_ir <= PW'(ai) * PW'(br);
   end

   // One extra bit holds the sum of two products without overflow
   always_comb begin
      re_sum = SW'(p_rr) - SW'(p_ii);
      im_sum = SW'(p_ri) + SW'(p_ir);
      re_sh  = (re_sum + HALF) >>> FRAC;
      im_sh  = (im_sum + HALF) >>> FRAC;
   end

`ifdef TWIDDLE_CMULT_SAT_EN
   localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (NBITS - 1)) - 1);
   localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (NBITS - 1)));

   always_comb begin
      if (re_sh > MAX_V)      re_lim = MAX_V[NBITS-1:0];
      else if (re_sh < MIN_V) re_lim = MIN_V[NBITS-1:0];
      else                    re_lim = re_sh[NBITS-1:0];
      if (im_sh > MAX_V)      im_lim = MAX_V[NBITS-1:0];
      else if (im_sh < MIN_V) im_lim = MIN_V[NBITS-1:0];
      else                    im_lim = im_sh[NBITS-1:0];
   end
`else
   logic unused_sh;

   always_comb begin
      re_lim = re_sh[NBITS-1:0];
      im_lim = im_sh[NBITS-1:0];
   end

   assign unused_sh = ^{re_sh[SW-1:NBITS], im_sh[SW-1:NBITS]};
`endif

   // Stage 3: data_out only loads on valid so bubbles hold the last result
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= v2;
         out_last  <= l2;
         if (v2) begin
            data_out <= {re_lim, im_lim};
         end
      end
   end

endmodule

// File: tb/tb_twiddle_cmult.sv
// Bench for twiddle_cmult: fixed vector table, frame/reset sequences and a randomized soak against a reference model.
module tb_twiddle_cmult;

   localparam int NB   = 11;
   localparam int NF   = 32;
   localparam int FR   = 9;
   localparam int DEPTH = 8192;

   logic            clk;
   logic            rst;
   logic [2*NB-1:0] data_in;
   logic            data_valid;
   logic [2*NB-1:0] coeff_in;
   logic [2*NB-1:0] data_out;
   logic            out_valid;
   logic            out_last;

   twiddle_cmult #(.NBITS(NB), .N(NF), .FRAC(FR)) dut (
      .clk(clk),
      .rst(rst),
      .data_in(data_in),
      .data_valid(data_valid),
      .coeff_in(coeff_in),
      .data_out(data_out),
      .out_valid(out_valid),
      .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int    ar, ai, br, bi;
      int    sr, si;
      int    wr, wi;
      string name;
   } vec_t;

   vec_t vt[8];

   bit            exp_v [DEPTH];
   bit            exp_l [DEPTH];
   logic [2*NB-1:0] exp_d [DEPTH];
   logic [2*NB-1:0] held;
   int            ecnt;
   int            fidx;
   int            n_pass;
   int            n_total;
   int            obs_v;
   int            last_cnt;
   int            last_at;

   function automatic vec_t mk(input int ar, input int ai, input int br, input int bi,
                               input int sr, input int si, input int wr, input int wi,
                               input string name);
      vec_t v;
      v.ar = ar; v.ai = ai; v.br = br; v.bi = bi;
      v.sr = sr; v.si = si; v.wr = wr; v.wi = wi;
      v.name = name;
      return v;
   endfunction

   // Round half up: floor((x + 0.5 LSB) / 2^FR)
   function automatic int rnd(input int x);
      int y;
      int q;
      y = x + 2 ** (FR - 1);
      q = y / (2 ** FR);
      if (y < 0 && q * (2 ** FR) != y) q = q - 1;
      return q;
   endfunction

   function automatic int lim(input int x);
      int m;
`ifdef TWIDDLE_CMULT_SAT_EN
      m = x;
      if (x > 2 ** (NB - 1) - 1) m = 2 ** (NB - 1) - 1;
      if (x < -(2 ** (NB - 1)))  m = -(2 ** (NB - 1));
`else
      m = x % (2 ** NB);
      if (m < 0) m = m + 2 ** NB;
      if (m >= 2 ** (NB - 1)) m = m - 2 ** NB;
`endif
      return m;
   endfunction

   function automatic logic [2*NB-1:0] ref_mult(input logic [2*NB-1:0] d, input logic [2*NB-1:0] c);
      int ar, ai, br, bi, re, im;
      logic [NB-1:0] ro, io;
      ar = int'($signed(d[2*NB-1:NB]));
      ai = int'($signed(d[NB-1:0]));
      br = int'($signed(c[2*NB-1:NB]));
      bi = int'($signed(c[NB-1:0]));
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
      ro = NB'(lim(rnd(re)));
      io = NB'(lim(rnd(im)));
      return {ro, io};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, ecnt);
   endtask

   // One clock: drive at negedge, update the model at posedge, compare 1 time unit later
   task automatic step(input logic v, input logic r, input logic [2*NB-1:0] d, input logic [2*NB-1:0] c);
      @(negedge clk);
      data_valid = v;
      rst        = r;
      data_in    = d;
      coeff_in   = c;
      @(posedge clk);
      ecnt++;
      if (r) begin
         for (int k = 0; k < 3; k++) exp_v[ecnt + k] = 1'b0;
         held = '0;
         fidx = 0;
      end else if (v) begin
         exp_v[ecnt + 2] = 1'b1;
         exp_d[ecnt + 2] = ref_mult(d, c);
         exp_l[ecnt + 2] = (fidx == NF - 1);
         fidx = (fidx + 1) % NF;
      end
      #1;
      if (exp_v[ecnt]) held = exp_d[ecnt];
      chk("out_valid", 32'(out_valid), 32'(exp_v[ecnt]));
      chk("out_last", 32'(out_last), 32'(exp_v[ecnt] & exp_l[ecnt]));
      chk("data_out", 32'(data_out), 32'(held));
      if (out_valid) begin
         obs_v++;
         if (out_last) begin
            last_cnt++;
            last_at = obs_v;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 22'($urandom), 22'($urandom));
   endtask

   initial begin
      logic [2*NB-1:0] d, c, e;
      int er, ei;

      vt[0] = mk(100, -50, 512, 0, 100, -50, 100, -50, "unity");
      vt[1] = mk(100, -50, 0, -512, -50, -100, -50, -100, "minus_j");
      vt[2] = mk(1, 0, 256, 0, 1, 0, 1, 0, "half_up");
      vt[3] = mk(1023, 1023, 512, 512, 0, 1023, 0, -2, "overflow_pos");
      vt[4] = mk(-1024, -1024, -512, 0, 1023, 1023, -1024, -1024, "overflow_neg");
      vt[5] = mk(-1, 0, 256, 0, 0, 0, 0, 0, "neg_half_up");
      vt[6] = mk(3, 0, 256, 0, 2, 0, 2, 0, "one_and_half");
      vt[7] = mk(-3, 5, 256, -256, 1, 4, 1, 4, "mixed");

      n_pass = 0; n_total = 0; ecnt = 0; fidx = 0; held = '0;
      obs_v = 0; last_cnt = 0; last_at = 0;
      rst = 1'b1; data_valid = 1'b0; data_in = '0; coeff_in = '0;

      step(1'b0, 1'b1, '0, '0);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_data", 32'(data_out), 32'd0);
      idle(2);

      foreach (vt[i]) begin
         d = {NB'(vt[i].ar), NB'(vt[i].ai)};
         c = {NB'(vt[i].br), NB'(vt[i].bi)};
         step(1'b1, 1'b0, d, c);
         idle(2);
`ifdef TWIDDLE_CMULT_SAT_EN
         er = vt[i].sr; ei = vt[i].si;
`else
         er = vt[i].wr; ei = vt[i].wi;
`endif
         e = {NB'(er), NB'(ei)};
         chk({vt[i].name, "_data"}, 32'(data_out), 32'(e));
         chk({vt[i].name, "_valid"}, 32'(out_valid), 32'd1);
         idle(1);
         chk({vt[i].name, "_width"}, 32'(out_valid), 32'd0);
      end

      // Frame of 32 with random gaps, plus one sample of the next frame
      step(1'b0, 1'b1, '0, '0);
      obs_v = 0; last_cnt = 0; last_at = 0;
      for (int i = 0; i < NF + 1; i++) begin
         step(1'b1, 1'b0, 22'($urandom), 22'($urandom));
         idle($urandom_range(0, 3));
      end
      idle(4);
      chk("frame_pulses", 32'(obs_v), 32'(NF + 1));
      chk("frame_last_cnt", 32'(last_cnt), 32'd1);
      chk("frame_last_at", 32'(last_at), 32'(NF));

      // Reset with two samples in flight and a valid input presented during reset
      obs_v = 0; last_cnt = 0; last_at = 0;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 22'($urandom), 22'($urandom));
      step(1'b1, 1'b1, 22'($urandom), 22'($urandom));
      chk("rst_data_zero", 32'(data_out), 32'd0);
      chk("rst_valid_zero", 32'(out_valid), 32'd0);
      idle(4);
      chk("rst_pulses", 32'(obs_v), 32'd8);
      obs_v = 0; last_cnt = 0; last_at = 0;
      for (int i = 0; i < NF; i++) begin
         step(1'b1, 1'b0, 22'($urandom), 22'($urandom));
         idle($urandom_range(0, 2));
      end
      idle(4);
      chk("post_rst_pulses", 32'(obs_v), 32'(NF));
      chk("post_rst_last_cnt", 32'(last_cnt), 32'd1);
      chk("post_rst_last_at", 32'(last_at), 32'(NF));

      // Randomized soak with occasional resets
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0),
              22'($urandom), 22'($urandom));
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/twiddle_cmult.md
TWIDDLE_CMULT -- requirements
Module: twiddle_cmult

Interface
REQ-001 The block SHALL have parameter NBITS, default 11, meaning signed width of each real/imaginary component.
REQ-002 The block SHALL have parameter N, default 32, meaning samples per frame (twiddle period).
REQ-003 The block SHALL have parameter FRAC, default NBITS-2, meaning fractional bits of the coefficient format (1.0 = 2^FRAC).
REQ-004 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port data_in  input  2*NBITS  sample, {real[2*NBITS-1:NBITS], imag[NBITS-1:0]}, two's complement.
REQ-007 The block SHALL have port data_valid  input  1  data_in is valid this cycle.
REQ-008 The block SHALL have port coeff_in  input  2*NBITS  twiddle factor from the coefficient generator, same packing as data_in.
REQ-009 The block SHALL have port data_out  output  2*NBITS  product data_in*coeff_in, same packing.
REQ-010 The block SHALL have port out_valid  output  1  data_out valid.
REQ-011 The block SHALL have port out_last  output  1  high with the product of frame sample N-1.

Function
REQ-012 The block SHALL capture data_in and coeff_in in the same cycle; coeff_in is sampled every cycle that data_valid is high.
REQ-013 The block SHALL be a 3-stage pipeline: S1 registers inputs; S2 registers ar*br, ai*bi, ar*bi, ai*br (2*NBITS signed each); S3 registers rounded/limited result.
REQ-014 Latency SHALL be exactly 3 cycles from data_valid high to out_valid high; one result per cycle; no backpressure.
REQ-015 The block SHALL compute re = ar*br - ai*bi and im = ar*bi + ai*br at 2*NBITS+1 bits, no intermediate truncation.
REQ-016 Rounding SHALL be round-half-up: add 2^(FRAC-1), then arithmetic shift right by FRAC.
REQ-017 The block SHALL limit the shifted value to NBITS as defined under Configuration.
REQ-018 valid SHALL propagate through a 3-bit shift register in lock-step with data; bubbles (data_valid low) SHALL produce out_valid low and hold data_out at its last value.
REQ-019 A frame counter, 0..N-1, SHALL increment on each accepted input and wrap N-1 -> 0.
REQ-020 The last flag SHALL be set for the input accepted at count N-1 and pipelined to out_last, aligned with out_valid.
REQ-021 out_last SHALL never be high while out_valid is low.
REQ-022 The counter SHALL hold during bubbles; a frame may span any number of idle cycles.

Reset
REQ-023 When rst is high at a clock edge, data_out SHALL become 0, out_valid 0, out_last 0, frame counter 0, and all pipeline valid bits 0.
REQ-024 Reset mid-frame SHALL discard all in-flight samples; the first input accepted after rst falls is frame sample 0.
REQ-025 An input presented with rst high SHALL be ignored.

Configuration
REQ-026 With macro TWIDDLE_CMULT_SAT_EN defined, results outside [-2^(NBITS-1), 2^(NBITS-1)-1] SHALL saturate to the nearest bound, per component.
REQ-027 Without TWIDDLE_CMULT_SAT_EN, results SHALL wrap: keep the low NBITS bits of the shifted value.

Verification (NBITS=11, FRAC=9, N=32)
REQ-028 data (100,-50), coeff (512,0), one valid pulse -> data_out (100,-50) with out_valid exactly 3 cycles later, one cycle wide.
REQ-029 data (100,-50), coeff (0,-512) -> data_out (-50,-100); data (1,0), coeff (256,0) -> (1,0) (half rounds up).
REQ-030 data (1023,1023), coeff (512,512) -> (0,1023) with TWIDDLE_CMULT_SAT_EN; (0,-2) without.
REQ-031 Frame: 32 valid inputs with random idle gaps -> 32 out_valid pulses; out_last only on the 32nd; 33rd input starts a new frame.
REQ-032 Reset: assert rst after 10 inputs with 2 in flight -> outputs 0 the next cycle, no stale out_valid; the next 32 inputs produce out_last on the 32nd.
